// File: rtl/demux_stream_1xn.sv
// ---------------------------------------------------------------------------
// demux_stream_1xn
//
// Registered, packet-aware 1-to-N stream demultiplexer. The destination lane
// is taken from s_sel on the first beat of a packet and held until the beat
// carrying s_last is accepted. A packet whose select is out of range
// (s_sel >= N) is accepted and silently discarded, and the sticky err_sel
// flag is raised.
//
// The block has a single output holding register {lane, data, last}, shared
// by all lanes. Only the lane named in that register shows valid/last/data.
// Every other lane drives zeros.
//
// Handshake (both sides): a beat moves when valid && ready in the same
// cycle. valid and the payload stay stable while valid && !ready. ready may
// depend combinationally on the other side's ready (s_ready follows
// m_ready[out_lane]), but valid never depends on ready.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        global enable, only sampled while no packet is open
//   s_sel     destination lane, sampled with the first beat of a packet
//   s_valid   input beat valid
//   s_data    input beat payload
//   s_last    input beat ends the packet
//   s_ready   input beat accepted when s_valid && s_ready
//   m_valid   per-lane valid
//   m_data    per-lane payload, lane i at [i*WIDTH +: WIDTH]
//   m_last    per-lane last flag
//   m_ready   per-lane ready
//   busy      a packet is open (forwarding or dropping)
//   err_sel   sticky: some packet arrived with s_sel >= N
//   state_dbg current FSM state (0 idle, 1 forward, 2 drop)
// ---------------------------------------------------------------------------
module demux_stream_1xn #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [SEL_W-1:0]   s_sel,
  input  logic               s_valid,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               s_last,
  output logic               s_ready,
  output logic [N-1:0]       m_valid,
  output logic [N*WIDTH-1:0] m_data,
  output logic [N-1:0]       m_last,
  input  logic [N-1:0]       m_ready,
  output logic               busy,
  output logic               err_sel,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Lane count widened by one bit so the range check is exact even when
  // 2^SEL_W == N.
  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  state_t             state_q, state_n;
  logic [SEL_W-1:0]   lane_q,  lane_n;
  logic               err_q;

  // Output holding register.
  logic               out_valid_q;
  logic [SEL_W-1:0]   out_lane_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_last_q;

  logic               sel_ok;
  logic               ready_sel;
  logic               can_load;
  logic               load;
  logic [SEL_W-1:0]   load_lane;
  logic               set_err;
  logic               ready_raw;

  // Ready of the lane currently held in the output register. Built as a
  // decode loop so a lane register value >= N can never index past m_ready.
  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (out_lane_q == SEL_W'(i)) ready_sel = m_ready[i];
    end
  end

  assign sel_ok   = ({1'b0, s_sel} < N_EXT);
  // The register can take a new beat if it is empty or being popped now.
  assign can_load = !out_valid_q || ready_sel;

  // Next-state and datapath control.
  always_comb begin
    state_n   = state_q;
    lane_n    = lane_q;
    ready_raw = 1'b0;
    load      = 1'b0;
    load_lane = lane_q;
    set_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // en gates only the start of a packet. A bad select is always
        // acceptable because the beat goes nowhere.
        if (en) ready_raw = sel_ok ? can_load : 1'b1;
        if (s_valid && ready_raw) begin
          if (sel_ok) begin
            load      = 1'b1;
            load_lane = s_sel;
            lane_n    = s_sel;
            if (!s_last) state_n = ST_FWD;
          end else begin
            set_err = 1'b1;
            if (!s_last) state_n = ST_DROP;
          end
        end
      end

      ST_FWD: begin
        // Mid-packet: s_sel and en are ignored, the captured lane is used.
        ready_raw = can_load;
        load_lane = lane_q;
        if (s_valid && ready_raw) begin
          load = 1'b1;
          if (s_last) state_n = ST_IDLE;
        end
      end

      ST_DROP: begin
        ready_raw = 1'b1;
        if (s_valid && s_last) state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Nothing is accepted while reset is applied.
  assign s_ready = ready_raw && !rst;

  // State, lane and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      lane_q  <= lane_n;
      if (set_err) err_q <= 1'b1;
    end
  end

  // Output register: a load takes priority over a pop, which gives
  // bubble-free reload when the held beat drains in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_lane_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_lane_q  <= load_lane;
      out_data_q  <= s_data;
      out_last_q  <= s_last;
    end else if (out_valid_q && ready_sel) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end
  end

  // Fan the single register out to its lane; all other lanes read zero.
  always_comb begin
    m_valid = '0;
    m_last  = '0;
    m_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (out_valid_q && (out_lane_q == SEL_W'(i))) begin
        m_valid[i]              = 1'b1;
        m_last[i]               = out_last_q;
        m_data[i*WIDTH +: WIDTH] = out_data_q;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign err_sel   = err_q;
  assign state_dbg = state_q;

endmodule

// File: doc/demux_stream_1xn.md
Name: demux_stream_1xn

Overview:
- Registered, packet-aware 1-to-N stream demultiplexer. It is the parametrised, sequential successor of the team's 1x2 enable/select demux.
- One input stream with valid/ready handshake is routed to one of N output lanes. Routing uses a select value captured on the first beat of each packet and held until the last beat.
- Sits between a packet source and N downstream consumers. Output is registered for timing closure.

Parameters:
- WIDTH, 8, data width per beat.
- N, 4, number of output lanes (2..16).
- SEL_W, 2, select width; must satisfy 2^SEL_W >= N.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  global enable; sampled only at packet boundaries.
- s_sel  input  SEL_W  destination lane; sampled with the first beat of a packet.
- s_valid  input  1  input beat valid.
- s_data  input  WIDTH  input beat data.
- s_last  input  1  marks final beat of packet.
- s_ready  output  1  input beat accepted when s_valid && s_ready.
- m_valid  output  N  per-lane valid.
- m_data  output  N*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- m_last  output  N  per-lane last flag.
- m_ready  input  N  per-lane ready.
- busy  output  1  high while a packet is open (FWD or DROP).
- err_sel  output  1  sticky flag: a packet arrived with s_sel >= N.

Behaviour:
- Reset values: m_valid=0, m_data=0, m_last=0, busy=0, err_sel=0, state=IDLE, lane register=0. s_ready is 0 during the cycle rst is high.
- States: IDLE, FWD, DROP.
- IDLE → FWD: s_valid && en && s_sel<N && beat accepted. Capture lane=s_sel.
- IDLE → DROP: s_valid && en && s_sel>=N. Set err_sel=1 and accept and discard the beat. If s_last=1 on that beat, stay in IDLE.
- IDLE, en=0: s_ready=0 and no beat is accepted. This is the stream analogue of "outputs 0 when disabled".
- FWD: s_sel is ignored and the captured lane is used. en is ignored mid-packet; a packet is never truncated by en.
- FWD → IDLE on acceptance of a beat with s_last=1. A single-beat packet goes IDLE → IDLE and drives the registered output directly.
- DROP: s_ready=1 and all beats are discarded. DROP → IDLE on accepted s_last.
- Output register is one entry per block, not per lane. It holds {lane, data, last}.
- Forwarding s_ready = !out_valid || m_ready[out_lane]. Back-to-back beats flow at 1 beat/cycle when the consumer is ready.
- Latency: an accepted beat appears on its lane's m_valid/m_data the next cycle.
- Non-selected lanes: m_valid=0, m_last=0, m_data slice = 0 (zeroed, not stale).
- A held beat stays stable until m_ready[out_lane]=1. It is never dropped, reordered, or altered while stalled.
- Simultaneous pop of the held beat and accept of a new beat in the same cycle: the register reloads with no bubble.
- Transition from a packet on lane A to a new packet on lane B while the A beat is still held: the new first beat waits (s_ready=0) until the held beat drains. A new packet may be accepted in the same cycle the old last beat pops.
- busy=1 from the cycle after a non-last first beat is accepted until the cycle after the last beat is accepted.
- err_sel clears only on rst.
- rst mid-packet: state returns to IDLE, the output register is cleared, and the partial packet is lost. The next beat after reset is treated as a first beat.

Test Plan:
- N=4, en=1, single-beat packet s_sel=2, s_data=0xA5, s_last=1, all m_ready=1 → next cycle m_valid=4'b0100, lane-2 data=0xA5, m_last[2]=1, other lanes data 0; busy stays 0.
- 3-beat packet, s_sel=1 on beat 0 then s_sel=3 on beats 1–2 → all three beats (0x11,0x22,0x33) appear on lane 1 only, consecutive cycles; busy=1 for 2 cycles.
- Lane 0 packet, m_ready[0]=0 for 3 cycles mid-packet → s_ready=0 during stall, lane-0 data held stable; no beat lost; resumes 1 beat/cycle when m_ready[0]=1.
- N=3 build, s_sel=3, 2-beat packet → s_ready=1, no m_valid on any lane, err_sel=1 and stays 1 after a following valid packet to lane 0.
- en=0 with s_valid=1 in IDLE → s_ready=0 indefinitely. en dropped to 0 mid-packet → packet completes to its lane; the next packet is blocked.
- rst=1 for one cycle after beat 1 of a 4-beat packet → m_valid=0, busy=0 next cycle; the following beat with s_sel=0 routes to lane 0 as a new packet.
